// File: rtl/logic_unit_pkg.sv
// Shared opcode encodings and default operand width for the logic_unit block.
// Shift operations are built only when LOGIC_UNIT_SHIFT_EN is defined.
package logic_unit_pkg;

   localparam int DATA_W_DEFAULT = 16;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_SHL  = 3'd6,
      OP_SHR  = 3'd7
   } opcode_e;

endpackage

// File: rtl/logic_unit_shifter.sv
// Combinational shifter: operand zero-extended to 2*DATA_W, so left shifts keep
// the bits that move past DATA_W-1. Only the low four bits of the amount are used.
module logic_unit_shifter #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0]   in_a,
   input  logic [3:0]          shamt,
   input  logic                shift_right,
   output logic [2*DATA_W-1:0] shift_out
);

   logic [2*DATA_W-1:0] a_ext;

   always_comb begin
      a_ext = {{DATA_W{1'b0}}, in_a};
      if (shift_right) begin
         shift_out = a_ext >> shamt;
      end else begin
         shift_out = a_ext << shamt;
      end
   end

endmodule

// File: rtl/logic_unit.sv
// Registered bitwise/shift unit with a zero flag; one-cycle latency, no handshake.
// Define LOGIC_UNIT_SHIFT_EN to build the shifter; otherwise opcodes 6/7 yield zero.
module logic_unit
   import logic_unit_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DATA_W-1:0]   in_a,
   input  logic [DATA_W-1:0]   in_b,
   input  logic [2:0]          opcode,
   output logic [2*DATA_W-1:0] out_logic,
   output logic                out_zero
);

   opcode_e             op;
   logic [DATA_W-1:0]   bit_res;
   logic [2*DATA_W-1:0] out_logic_d, out_logic_q;
   logic                out_zero_d, out_zero_q;

`ifdef LOGIC_UNIT_SHIFT_EN
   logic [2*DATA_W-1:0] shift_res;

   logic_unit_shifter #(
      .DATA_W (DATA_W)
   ) u_shifter (
      .in_a        (in_a),
      .shamt       (in_b[3:0]),
      .shift_right (op == OP_SHR),
      .shift_out   (shift_res)
   );
`endif

   always_comb begin
      op          = opcode_e'(opcode);
      bit_res     = '0;
      out_logic_d = '0;
      case (op)
         OP_AND:  bit_res = in_a & in_b;
         OP_OR:   bit_res = in_a | in_b;
         OP_XOR:  bit_res = in_a ^ in_b;
         OP_NAND: bit_res = ~(in_a & in_b);
         OP_NOR:  bit_res = ~(in_a | in_b);
         OP_XNOR: bit_res = ~(in_a ^ in_b);
         default: bit_res = '0;
      endcase
      // Bitwise results occupy the low half only; shifts use the full width.
      if (op == OP_SHL || op == OP_SHR) begin
`ifdef LOGIC_UNIT_SHIFT_EN
         out_logic_d = shift_res;
`else
         out_logic_d = '0;
`endif
      end else begin
         out_logic_d = {{DATA_W{1'b0}}, bit_res};
      end
      out_zero_d = (out_logic_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_logic_q <= '0;
         out_zero_q  <= 1'b1;
      end else begin
         out_logic_q <= out_logic_d;
         out_zero_q  <= out_zero_d;
      end
   end

   assign out_logic = out_logic_q;
   assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_logic_unit.sv
// Directed bench for logic_unit: reset behaviour, opcode sweep, shift edge cases,
// zero flag and hold/mid-cycle behaviour. Shift expectations follow LOGIC_UNIT_SHIFT_EN.
module tb_logic_unit;
   import logic_unit_pkg::*;

   localparam int DATA_W = 16;
   localparam int RES_W  = 2 * DATA_W;

`ifdef LOGIC_UNIT_SHIFT_EN
   localparam bit SHIFT_EN = 1'b1;
`else
   localparam bit SHIFT_EN = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic [2:0]        opcode;
   logic [RES_W-1:0]  out_logic;
   logic              out_zero;

   int checks = 0;
   int errors = 0;
   logic [RES_W-1:0] exp_q[$];

   logic_unit #(
      .DATA_W (DATA_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_a      (in_a),
      .in_b      (in_b),
      .opcode    (opcode),
      .out_logic (out_logic),
      .out_zero  (out_zero)
   );

   // Clock and reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [RES_W-1:0] sh_exp(input logic [RES_W-1:0] v);
      return SHIFT_EN ? v : '0;
   endfunction

   task automatic check(input string tag, input logic [RES_W-1:0] exp_l, input logic exp_z);
      checks++;
      assert (out_logic === exp_l) else begin
         errors++;
         $error("FAIL %s out_logic got %h expected %h", tag, out_logic, exp_l);
      end
      checks++;
      assert (out_zero === exp_z) else begin
         errors++;
         $error("FAIL %s out_zero got %b expected %b", tag, out_zero, exp_z);
      end
   endtask

   // Driver: apply operands at the falling edge, sample 1 time unit after the next rising edge.
   task automatic step(input string tag, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [2:0] op, input logic [RES_W-1:0] exp_l);
      logic [RES_W-1:0] e;
      @(negedge clk);
      in_a   = a;
      in_b   = b;
      opcode = op;
      exp_q.push_back(exp_l);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check(tag, e, (e == '0));
   endtask

   initial begin
      rst_n  = 1'b1;
      in_a   = 16'h0005;
      in_b   = 16'h0000;
      opcode = 3'd1;
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_async", '0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("reset_held", '0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_first_edge", 32'h0000_0005, 1'b0);

      step("sweep_and",  16'h0004, 16'h0007, 3'd0, 32'h0000_0004);
      step("sweep_or",   16'h0004, 16'h0007, 3'd1, 32'h0000_0007);
      step("sweep_xor",  16'h0004, 16'h0007, 3'd2, 32'h0000_0003);
      step("sweep_nand", 16'h0004, 16'h0007, 3'd3, 32'h0000_FFFB);
      step("sweep_nor",  16'h0004, 16'h0007, 3'd4, 32'h0000_FFF8);
      step("sweep_xnor", 16'h0004, 16'h0007, 3'd5, 32'h0000_FFFC);
      step("sweep_shl",  16'h0004, 16'h0007, 3'd6, sh_exp(32'h0000_0200));
      step("sweep_shr",  16'h0004, 16'h0007, 3'd7, 32'h0000_0000);

      step("shl_carry",  16'hFFFF, 16'h000F, 3'd6, sh_exp(32'h7FFF_8000));
      step("shr_carry",  16'hFFFF, 16'h000F, 3'd7, sh_exp(32'h0000_0001));
      step("shl_mask",   16'h0001, 16'hFFF3, 3'd6, sh_exp(32'h0000_0008));
      step("shr_zero",   16'hABCD, 16'h0010, 3'd7, sh_exp(32'h0000_ABCD));
      step("shl_zero",   16'hABCD, 16'h0010, 3'd6, sh_exp(32'h0000_ABCD));

      step("zero_and",   16'h00FF, 16'hFF00, 3'd0, 32'h0000_0000);
      step("zero_or",    16'h00FF, 16'hFF00, 3'd1, 32'h0000_FFFF);

      // Stable inputs hold the result across further edges.
      @(posedge clk);
      #1;
      check("hold", 32'h0000_FFFF, 1'b0);

      // Opcode change between edges is visible only after the next edge.
      #2;
      opcode = 3'd0;
      #1;
      check("mid_cycle_op", 32'h0000_FFFF, 1'b0);
      @(posedge clk);
      #1;
      check("mid_cycle_next", 32'h0000_0000, 1'b1);

      // Reset mid-operation clears the output without waiting for a clock edge.
      step("pre_reset", 16'h1234, 16'h0F0F, 3'd2, 32'h0000_1D3B);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_mid_op", '0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_release", 32'h0000_1D3B, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog: the directed sequence is short; stop if it somehow stalls.
   initial begin
      #20000;
      errors++;
      $display("FAIL watchdog timeout got running expected finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/logic_unit.md
LOGIC_UNIT -- requirements
Module: logic_unit

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the operand width; the result width is 2*DATA_W.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 in_a  input  DATA_W  SHALL be operand A, unsigned.
REQ-005 in_b  input  DATA_W  SHALL be operand B, unsigned; bits [3:0] are also the shift amount.
REQ-006 opcode  input  3  SHALL select the operation per REQ-010.
REQ-007 out_logic  output  2*DATA_W  SHALL be the registered result.
REQ-008 out_zero  output  1  SHALL be the registered flag, high when the next-state out_logic is all zeros.

Function
REQ-009 On every rising clk edge with rst_n high, the block SHALL sample in_a, in_b and opcode and load out_logic and out_zero; latency is exactly 1 cycle, with no enable and no handshake.
REQ-010 Opcode map: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 SHL, 7 SHR.
REQ-011 Opcodes 0-5 SHALL compute bitwise on DATA_W bits and zero-extend into out_logic; upper DATA_W bits are always 0.
REQ-012 SHL SHALL be {DATA_W zeros, in_a} shifted left by in_b[3:0] at full 2*DATA_W width, so bits shifted past bit DATA_W-1 are kept, not lost.
REQ-013 SHR SHALL be zero-extended in_a logically shifted right by in_b[3:0]; shift amount 0 passes in_a unchanged.
REQ-014 Only in_b[3:0] SHALL affect shifts; in_b[DATA_W-1:4] is ignored for opcodes 6-7.
REQ-015 Output SHALL hold its value while inputs are stable; an opcode change mid-cycle SHALL affect only the next edge.
REQ-016 There SHALL be no illegal opcode; all 8 codes are defined.

Reset
REQ-017 While rst_n is low, out_logic SHALL be 0 and out_zero SHALL be 1, asynchronously, regardless of clk.
REQ-018 The first rising edge after rst_n deasserts SHALL load a normal result per REQ-009.
REQ-019 Reset asserted mid-operation SHALL discard any pending result immediately.

Configuration
REQ-020 Macro LOGIC_UNIT_SHIFT_EN SHALL gate the shift operations.
REQ-021 With LOGIC_UNIT_SHIFT_EN defined, opcodes 6 and 7 SHALL behave per REQ-012 and REQ-013.
REQ-022 Without LOGIC_UNIT_SHIFT_EN, opcodes 6 and 7 SHALL yield out_logic 0 and out_zero 1, and no shifter logic is built.

Structure
REQ-023 Package logic_unit_pkg SHALL hold the opcode constants (OP_AND..OP_SHR) and the default DATA_W.
REQ-024 The shifter SHALL be one sub-module, logic_unit_shifter (combinational, DATA_W parameter, 2*DATA_W output), instantiated only under LOGIC_UNIT_SHIFT_EN.
REQ-025 The top SHALL contain the combinational op mux plus the output/flag register.

Verification
REQ-026 Reset: hold rst_n low with clk running -> out_logic 0x00000000, out_zero 1; release -> first edge loads the result.
REQ-027 Sweep: in_a=0x0004, in_b=0x0007, opcode 0..7, one per cycle -> 0x4, 0x7, 0x3, 0xFFFB, 0xFFF8, 0xFFFC, 0x200, 0x0 (SHR sets out_zero=1), each 1 cycle after the opcode is applied.
REQ-028 Shift carry-out: in_a=0xFFFF, in_b=0x000F, opcode 6 -> out_logic 0x7FFF8000; opcode 7 -> 0x00000001.
REQ-029 Shift mask: in_a=0x0001, in_b=0xFFF3, opcode 6 -> 0x00000008, showing only in_b[3:0] is used.
REQ-030 Zero flag: in_a=0x00FF, in_b=0xFF00, opcode 0 -> out_logic 0, out_zero 1; opcode 1 -> 0x0000FFFF, out_zero 0.
REQ-031 Build without LOGIC_UNIT_SHIFT_EN, opcode 6 with in_a=0x0004, in_b=0x0007 -> out_logic 0, out_zero 1.
